// File: rtl/tp84_hs_ram_ctrl.sv
// tp84_hs_ram_ctrl: arbitrates hiscore-engine access to the CPU work RAM shared port.
// The CPU is halted, the bus is allowed to settle for a few bus cycles (or a timeout),
// then the RAM port is handed to the hiscore engine until it drops its request.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | CPU owns the bus, no hiscore activity
// HALT    | CPU halted, counting cycle-end pulses / timeout before grant
// GRANT   | hiscore engine owns the RAM shared port
// RELEASE | port returned, halt held for HOLD cycles before CPU resumes
module tp84_hs_ram_ctrl #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned HOLD    = 4
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic        hs_req,
    input  logic        user_pause,
    input  logic        cpu_cycle_end,
    input  logic [15:0] hs_address,
    input  logic [7:0]  hs_data_in,
    input  logic        hs_write,
    input  logic [7:0]  ram_q,
    output logic        cpu_halt,
    output logic        hs_grant,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic [7:0]  hs_data_out,
    output logic        hs_rd_valid
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HALT    = 2'd1;
    localparam logic [1:0] S_GRANT   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [2:0]    SETTLE_MAX  = 3'd7;
    localparam logic [9:0]    TIMEOUT_MAX = 10'h3FF;

    logic [1:0]    r_state;
    logic [1:0]    w_nxt;
    logic [2:0]    r_settle_cnt;
    logic [9:0]    r_timeout_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_cpu_halt;
    logic          r_grant;
    logic [15:0]   r_ram_addr;
    logic [7:0]    r_ram_din;
    logic          r_ram_we;
    logic [7:0]    r_data_out;
    logic          r_rd_valid;
    logic          r_addr_chg_d1;
    logic          r_addr_chg_d2;
    logic          w_in_grant;
    logic          w_enter_halt;
    logic          w_enter_release;

    assign w_in_grant      = (r_state == S_GRANT);
    assign w_enter_halt    = (w_nxt == S_HALT) && (r_state != S_HALT);
    assign w_enter_release = (w_nxt == S_RELEASE) && (r_state != S_RELEASE);

    // Next-state decision; a dropped request always wins over the grant condition.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (hs_req) w_nxt = S_HALT;
            end
            S_HALT: begin
                if (!hs_req)
                    w_nxt = S_RELEASE;
                else if ((r_settle_cnt == 3'(SETTLE)) || (r_timeout_cnt == 10'(TIMEOUT)))
                    w_nxt = S_GRANT;
            end
            S_GRANT: begin
                if (!hs_req) w_nxt = S_RELEASE;
            end
            default: begin
                if (hs_req)
                    w_nxt = S_HALT;
                else if (r_hold_cnt == HW'(HOLD - 1))
                    w_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus the halt/grant outputs, registered from the next state.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cpu_halt <= 1'b0;
            r_grant    <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_cpu_halt <= (w_nxt != S_IDLE) || user_pause;
            r_grant    <= (w_nxt == S_GRANT);
        end
    end

    // Saturating settle/timeout/hold counters; cleared on entry so the entry edge never counts.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            r_settle_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_hold_cnt    <= '0;
        end else begin
            if (w_enter_halt) begin
                r_settle_cnt  <= '0;
                r_timeout_cnt <= '0;
            end else if (r_state == S_HALT) begin
                if (cpu_cycle_end && (r_settle_cnt != SETTLE_MAX))
                    r_settle_cnt <= r_settle_cnt + 3'd1;
                if (r_timeout_cnt != TIMEOUT_MAX)
                    r_timeout_cnt <= r_timeout_cnt + 10'd1;
            end
            if (w_enter_release)
                r_hold_cnt <= '0;
            else if ((r_state == S_RELEASE) && (r_hold_cnt != HW'(HOLD - 1)))
                r_hold_cnt <= r_hold_cnt + HW'(1);
        end
    end

    // RAM-side registers: follow the engine while granted, hold otherwise; no write on the release edge.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_we   <= 1'b0;
        end else begin
            if (w_in_grant) begin
                r_ram_addr <= hs_address;
                r_ram_din  <= hs_data_in;
            end
            r_ram_we <= w_in_grant && (w_nxt == S_GRANT) && hs_write;
        end
    end

    // Read return: address-change flag is pipelined to line up with the synchronous RAM output.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            r_addr_chg_d1 <= 1'b0;
            r_addr_chg_d2 <= 1'b0;
            r_data_out    <= '0;
            r_rd_valid    <= 1'b0;
        end else begin
            r_addr_chg_d1 <= w_in_grant && (hs_address != r_ram_addr);
            r_addr_chg_d2 <= r_addr_chg_d1;
            if (w_in_grant)
                r_data_out <= ram_q;
            r_rd_valid <= w_in_grant && r_addr_chg_d2;
        end
    end

    assign cpu_halt    = r_cpu_halt;
    assign hs_grant    = r_grant;
    assign ram_addr    = r_ram_addr;
    assign ram_din     = r_ram_din;
    assign ram_we      = r_ram_we;
    assign hs_data_out = r_data_out;
    assign hs_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_tp84_hs_ram_ctrl.sv
// Directed testbench for tp84_hs_ram_ctrl: grant sequencing, write/read path,
// release/re-request, pause merge, async reset during grant, timeout, aborted halt.
module tb_tp84_hs_ram_ctrl;

    logic        clk_49m;
    logic        reset;
    logic        hs_req;
    logic        user_pause;
    logic        cpu_cycle_end;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_in;
    logic        hs_write;
    logic [7:0]  ram_q;
    logic        cpu_halt;
    logic        hs_grant;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  hs_data_out;
    logic        hs_rd_valid;

    int checks   = 0;
    int failures = 0;
    int n;

    tp84_hs_ram_ctrl dut (
        .clk_49m      (clk_49m),
        .reset        (reset),
        .hs_req       (hs_req),
        .user_pause   (user_pause),
        .cpu_cycle_end(cpu_cycle_end),
        .hs_address   (hs_address),
        .hs_data_in   (hs_data_in),
        .hs_write     (hs_write),
        .ram_q        (ram_q),
        .cpu_halt     (cpu_halt),
        .hs_grant     (hs_grant),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .hs_data_out  (hs_data_out),
        .hs_rd_valid  (hs_rd_valid)
    );

    initial clk_49m = 1'b0;
    always #10 clk_49m = ~clk_49m;

    // Synchronous RAM model: data one cycle after the address is presented.
    function automatic logic [7:0] ram_lookup(input logic [15:0] a);
        case (a)
            16'h5700: return 8'h3C;
            16'h5701: return 8'h7E;
            default:  return 8'h00;
        endcase
    endfunction

    always @(posedge clk_49m) ram_q <= ram_lookup(ram_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_49m);
        #1;
    endtask

    initial begin
        reset = 1'b1; hs_req = 1'b0; user_pause = 1'b0; cpu_cycle_end = 1'b0;
        hs_address = 16'h0000; hs_data_in = 8'h00; hs_write = 1'b0; ram_q = 8'h00;
        #2 reset = 1'b0;
        tick(); tick();
        check("rst_cpu_halt", 32'(cpu_halt), 32'd0);
        check("rst_hs_grant", 32'(hs_grant), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_din", 32'(ram_din), 32'h0);
        check("rst_data_out", 32'(hs_data_out), 32'h0);
        check("rst_rd_valid", 32'(hs_rd_valid), 32'd0);
        reset = 1'b1;
        tick();

        // Pause only gates the CPU
        user_pause = 1'b1;
        tick();
        check("pause_halt", 32'(cpu_halt), 32'd1);
        check("pause_grant", 32'(hs_grant), 32'd0);
        user_pause = 1'b0;
        tick();
        check("unpause_halt", 32'(cpu_halt), 32'd0);

        // Normal grant: request at cycle 0, pulses at cycles 5 and 12, grant at 14
        hs_req = 1'b1;
        check("c0_halt", 32'(cpu_halt), 32'd0);
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) check("c1_halt", 32'(cpu_halt), 32'd1);
            if (c <= 13) check("halt_no_we", 32'(ram_we), 32'd0);
            if (c == 13) check("c13_grant", 32'(hs_grant), 32'd0);
            if (c == 14) check("c14_grant", 32'(hs_grant), 32'd1);
            cpu_cycle_end = (c == 5) || (c == 12);
        end
        cpu_cycle_end = 1'b0;

        // Single-cycle write
        hs_address = 16'h5780; hs_data_in = 8'hA5; hs_write = 1'b1;
        tick();
        check("wr_we", 32'(ram_we), 32'd1);
        check("wr_addr", 32'(ram_addr), 32'h5780);
        check("wr_din", 32'(ram_din), 32'hA5);
        hs_write = 1'b0;
        tick();
        check("wr_we_off", 32'(ram_we), 32'd0);
        repeat (5) tick();

        // Reads: valid on the third edge after the address is driven
        hs_address = 16'h5700;
        tick(); tick();
        check("rd0_early", 32'(hs_rd_valid), 32'd0);
        tick();
        check("rd0_valid", 32'(hs_rd_valid), 32'd1);
        check("rd0_data", 32'(hs_data_out), 32'h3C);
        tick();
        check("rd0_pulse_end", 32'(hs_rd_valid), 32'd0);
        hs_address = 16'h5701;
        tick(); tick();
        check("rd1_early", 32'(hs_rd_valid), 32'd0);
        tick();
        check("rd1_valid", 32'(hs_rd_valid), 32'd1);
        check("rd1_data", 32'(hs_data_out), 32'h7E);
        tick();
        check("rd1_pulse_end", 32'(hs_rd_valid), 32'd0);

        // Release, re-request two cycles later, re-grant after two pulses
        hs_req = 1'b0;
        tick();
        check("rel_grant", 32'(hs_grant), 32'd0);
        check("rel_we", 32'(ram_we), 32'd0);
        check("rel_halt", 32'(cpu_halt), 32'd1);
        tick();
        check("rel2_halt", 32'(cpu_halt), 32'd1);
        hs_req = 1'b1;
        tick();
        check("rereq_halt", 32'(cpu_halt), 32'd1);
        tick();
        cpu_cycle_end = 1'b1;
        tick();
        cpu_cycle_end = 1'b0;
        tick(); tick();
        check("rereq_mid_halt", 32'(cpu_halt), 32'd1);
        check("rereq_mid_grant", 32'(hs_grant), 32'd0);
        cpu_cycle_end = 1'b1;
        tick();
        cpu_cycle_end = 1'b0;
        check("rereq_pre_grant", 32'(hs_grant), 32'd0);
        tick();
        check("rereq_grant", 32'(hs_grant), 32'd1);

        // Async reset while granted and writing
        hs_write = 1'b1;
        tick();
        check("pre_rst_we", 32'(ram_we), 32'd1);
        #3 reset = 1'b0;
        #1;
        check("arst_halt", 32'(cpu_halt), 32'd0);
        check("arst_grant", 32'(hs_grant), 32'd0);
        check("arst_we", 32'(ram_we), 32'd0);
        hs_write = 1'b0; hs_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_halt", 32'(cpu_halt), 32'd0);
        check("post_rst_grant", 32'(hs_grant), 32'd0);

        // Timeout: no pulses, grant 1024 cycles after HALT entry (entry is cycle 1)
        hs_req = 1'b1;
        n = 0;
        while (!hs_grant && n < 1100) begin
            tick();
            n++;
            if (n == 1) check("to_entry_halt", 32'(cpu_halt), 32'd1);
        end
        check("to_granted", 32'(hs_grant), 32'd1);
        check("to_latency_ok", 32'((n - 1 >= 1023) && (n - 1 <= 1025)), 32'd1);

        // Abort in HALT: release without grant, halt held for 4 cycles
        hs_req = 1'b0;
        repeat (6) tick();
        check("to_idle_halt", 32'(cpu_halt), 32'd0);
        hs_req = 1'b1;
        tick(); tick();
        hs_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("abort_no_grant", 32'(hs_grant), 32'd0);
            check("abort_halt", 32'(cpu_halt), (k <= 4) ? 32'd1 : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
